// File: rtl/i2c_eeprom_seq.sv
// i2c_eeprom_seq
// Turns one random-access EEPROM byte command (write or read) into the
// register-write / status-poll sequence of the I2C master core, then
// reports read data together with NACK / timeout status.
module i2c_eeprom_seq #(
    parameter logic [15:0] PRESCALE = 16'd199,
    parameter logic [23:0] TIMEOUT  = 24'd1_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_rd,
    input  logic [6:0] cmd_dev,
    input  logic [7:0] cmd_mem,
    input  logic [7:0] cmd_wdata,
    output logic       rsp_valid,
    output logic [7:0] rsp_rdata,
    output logic       rsp_nack,
    output logic       rsp_tmo,
    output logic [2:0] reg_adr,
    output logic [7:0] reg_wdat,
    output logic       reg_we,
    input  logic [7:0] reg_rdat
);

    // Core register addresses
    localparam logic [2:0] ADR_PRERLO = 3'd0;
    localparam logic [2:0] ADR_PRERHI = 3'd1;
    localparam logic [2:0] ADR_CTR    = 3'd2;
    localparam logic [2:0] ADR_TXRX   = 3'd3;
    localparam logic [2:0] ADR_CRSR   = 3'd4;

    // Command register values
    localparam logic [7:0] CR_STA_WR  = 8'h90;
    localparam logic [7:0] CR_WR      = 8'h10;
    localparam logic [7:0] CR_STO_WR  = 8'h50;
    localparam logic [7:0] CR_RD_NACK = 8'h68;
    localparam logic [7:0] CR_STO     = 8'h40;
    localparam logic [7:0] CTR_EN     = 8'h80;

    // Each state names what is on the register bus during that cycle;
    // the bus registers are loaded on the transition into the state.
    typedef enum logic [3:0] {
        S_INIT0,
        S_INIT1,
        S_INIT2,
        S_INIT3,
        S_IDLE,
        S_TXR,
        S_CR,
        S_WAIT1,
        S_WAIT2,
        S_POLL,
        S_TMO_CR,
        S_RXR,
        S_DONE
    } state_t;

    state_t      state;
    logic        rd_q;
    logic [6:0]  dev_q;
    logic [7:0]  mem_q;
    logic [7:0]  wdata_q;
    logic [1:0]  step;
    logic        stopping;
    logic [23:0] tmo_cnt;

    // Byte loaded into TXR for a given byte step
    function automatic logic [7:0] txr_val(input logic [1:0] s);
        case (s)
            2'd0:    txr_val = {dev_q, 1'b0};
            2'd1:    txr_val = mem_q;
            default: txr_val = rd_q ? {dev_q, 1'b1} : wdata_q;
        endcase
    endfunction

    // Command written to CR for a given byte step
    function automatic logic [7:0] cr_val(input logic [1:0] s);
        case (s)
            2'd0:    cr_val = CR_STA_WR;
            2'd1:    cr_val = CR_WR;
            2'd2:    cr_val = rd_q ? CR_STA_WR : CR_STO_WR;
            default: cr_val = CR_RD_NACK;
        endcase
    endfunction

    // Sequencer FSM with registered bus and response outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_INIT0;
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_nack  <= 1'b0;
            rsp_tmo   <= 1'b0;
            reg_we    <= 1'b0;
            reg_adr   <= '0;
            reg_wdat  <= '0;
            rd_q      <= 1'b0;
            dev_q     <= '0;
            mem_q     <= '0;
            wdata_q   <= '0;
            step      <= '0;
            stopping  <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            reg_we    <= 1'b0;
            reg_adr   <= ADR_CRSR;
            reg_wdat  <= '0;
            rsp_valid <= 1'b0;

            case (state)
                S_INIT0: begin
                    state    <= S_INIT1;
                    reg_we   <= 1'b1;
                    reg_adr  <= ADR_PRERLO;
                    reg_wdat <= PRESCALE[7:0];
                end
                S_INIT1: begin
                    state    <= S_INIT2;
                    reg_we   <= 1'b1;
                    reg_adr  <= ADR_PRERHI;
                    reg_wdat <= PRESCALE[15:8];
                end
                S_INIT2: begin
                    state    <= S_INIT3;
                    reg_we   <= 1'b1;
                    reg_adr  <= ADR_CTR;
                    reg_wdat <= CTR_EN;
                end
                S_INIT3: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
                S_IDLE: begin
                    if (cmd_valid && cmd_ready) begin
                        cmd_ready <= 1'b0;
                        rd_q      <= cmd_rd;
                        dev_q     <= cmd_dev;
                        mem_q     <= cmd_mem;
                        wdata_q   <= cmd_wdata;
                        rsp_rdata <= '0;
                        rsp_nack  <= 1'b0;
                        rsp_tmo   <= 1'b0;
                        step      <= '0;
                        stopping  <= 1'b0;
                        state     <= S_TXR;
                        reg_we    <= 1'b1;
                        reg_adr   <= ADR_TXRX;
                        reg_wdat  <= {cmd_dev, 1'b0};
                    end
                end
                S_TXR: begin
                    state    <= S_CR;
                    reg_we   <= 1'b1;
                    reg_adr  <= ADR_CRSR;
                    reg_wdat <= cr_val(step);
                end
                S_CR: begin
                    state <= S_WAIT1;
                end
                S_WAIT1: begin
                    state <= S_WAIT2;
                end
                S_WAIT2: begin
                    state   <= S_POLL;
                    tmo_cnt <= '0;
                end
                S_POLL: begin
                    if (reg_rdat[1]) begin
                        if (tmo_cnt == TIMEOUT - 24'd1) begin
                            rsp_tmo  <= 1'b1;
                            state    <= S_TMO_CR;
                            reg_we   <= 1'b1;
                            reg_adr  <= ADR_CRSR;
                            reg_wdat <= CR_STO;
                        end else begin
                            tmo_cnt <= tmo_cnt + 24'd1;
                        end
                    end else if (stopping) begin
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                    end else if (rd_q && step == 2'd3) begin
                        // master-NACKed read byte: RxACK is meaningless here
                        state   <= S_RXR;
                        reg_adr <= ADR_TXRX;
                    end else if (reg_rdat[7]) begin
                        // slave NACK: issue STOP, then one more poll before DONE
                        rsp_nack <= 1'b1;
                        stopping <= 1'b1;
                        state    <= S_CR;
                        reg_we   <= 1'b1;
                        reg_adr  <= ADR_CRSR;
                        reg_wdat <= CR_STO;
                    end else if (!rd_q && step == 2'd2) begin
                        state     <= S_DONE;
                        rsp_valid <= 1'b1;
                    end else begin
                        step <= step + 2'd1;
                        if (rd_q && step == 2'd2) begin
                            // read byte has no TXR load, go straight to CR
                            state    <= S_CR;
                            reg_we   <= 1'b1;
                            reg_adr  <= ADR_CRSR;
                            reg_wdat <= CR_RD_NACK;
                        end else begin
                            state    <= S_TXR;
                            reg_we   <= 1'b1;
                            reg_adr  <= ADR_TXRX;
                            reg_wdat <= txr_val(step + 2'd1);
                        end
                    end
                end
                S_TMO_CR: begin
                    state     <= S_DONE;
                    rsp_valid <= 1'b1;
                end
                S_RXR: begin
                    rsp_rdata <= reg_rdat;
                    state     <= S_DONE;
                    rsp_valid <= 1'b1;
                end
                S_DONE: begin
                    state     <= S_IDLE;
                    cmd_ready <= 1'b1;
                end
                default: begin
                    state <= S_INIT0;
                end
            endcase
        end
    end

endmodule
